// File: rtl/gray_pkg.sv
// gray_pkg: shared helpers and types for the gray-code counter family.
// Conversion functions work on 32-bit values; callers zero-extend and truncate to their width.
package gray_pkg;

    localparam int unsigned GRAY_MAX_WIDTH = 32;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended inputs decode correctly at any width.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_w.sv
// gray2bin_w: combinational gray-to-binary converter of configurable width.
// Shared by the counter's self-check and by downstream FIFO pointer comparison.
module gray2bin_w
    import gray_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin
);

    assign bin = DATA_WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray)));

endmodule

// File: rtl/gray_counter_ud.sv
// gray_counter_ud: synchronous up/down gray-code counter with enable, parallel load,
// wrap or saturate at the range ends, terminal-count pulse and a registered binary mirror.
// DATA_WIDTH is legal from 2 to 32.
// Optional macro GRAY_ONEHOT_CHECK_EN adds chk_err, a sticky flag raised when out_gray
// changes in more than one bit outside the cycle following a load or reset.
module gray_counter_ud
    import gray_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 4,
    parameter int unsigned           WRAP_MODE  = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_BIN  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_bin,
    output logic [DATA_WIDTH-1:0] out_gray,
    output logic [DATA_WIDTH-1:0] out_bin,
    output logic                  tc,
    output logic                  sat
`ifdef GRAY_ONEHOT_CHECK_EN
    ,
    output logic                  chk_err
`endif
);

    localparam bit                    SAT_MODE = (WRAP_MODE == 0);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] ZERO     = '0;

    dir_e                  step_dir;
    logic [DATA_WIDTH-1:0] end_val;
    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [DATA_WIDTH-1:0] gray_q, gray_d;
    logic                  tc_q, tc_d;
    logic                  sat_q, sat_d;
    logic [DATA_WIDTH-1:0] mirror_bin;

    assign step_dir = dir_e'(dir);
    // End of travel in the sampled direction: all-ones going up, zero going down.
    assign end_val  = (step_dir == DIR_UP) ? ALL_ONES : ZERO;

    // Next state: load beats a step; in saturate mode a step past the end holds and flags sat.
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        sat_d = sat_q;
        if (load) begin
            bin_d = load_bin;
            sat_d = SAT_MODE && ((load_bin == ALL_ONES) || (load_bin == ZERO));
        end else if (en) begin
            if (SAT_MODE && (bin_q == end_val)) begin
                sat_d = 1'b1;
            end else begin
                bin_d = (step_dir == DIR_UP) ? bin_q + 1'b1 : bin_q - 1'b1;
                tc_d  = (bin_d == end_val);
                sat_d = SAT_MODE && tc_d;
            end
        end
    end

    assign gray_d = DATA_WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_d)));

    // State and output registers; gray and binary load together so they stay cycle-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= RESET_BIN;
            gray_q <= DATA_WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RESET_BIN)));
            tc_q   <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
            sat_q  <= sat_d;
        end
    end

    assign out_bin  = bin_q;
    assign out_gray = gray_q;
    assign tc       = tc_q;
    assign sat      = sat_q;

    gray2bin_w #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mirror (
        .gray(gray_q),
        .bin (mirror_bin)
    );

    // Decoding the registered gray must always reproduce the binary register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (mirror_bin == bin_q);
        end
    end

`ifdef GRAY_ONEHOT_CHECK_EN
    logic [DATA_WIDTH-1:0] prev_gray_q;
    logic [DATA_WIDTH-1:0] gray_diff;
    logic                  fresh_q;
    logic                  multi_bit;
    logic                  chk_err_q;

    assign gray_diff = out_gray ^ prev_gray_q;
    // More than one bit set in the diff; the cycle after a load or reset may jump freely.
    assign multi_bit = !fresh_q && ((gray_diff & (gray_diff - 1'b1)) != ZERO);

    // Track the previous gray code and latch any multi-bit transition until reset.
    always_ff @(posedge clk) begin
        prev_gray_q <= gray_q;
        fresh_q     <= rst | load;
        if (rst) begin
            chk_err_q <= 1'b0;
        end else begin
            assert (!multi_bit);
            if (multi_bit) begin
                chk_err_q <= 1'b1;
            end
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_gray_counter_ud.sv
// tb_gray_counter_ud: directed and randomized checks of gray_counter_ud against a
// value-level reference model. Three instances: 4-bit wrap, 4-bit saturate (RESET_BIN=3)
// and 8-bit wrap. Honours GRAY_ONEHOT_CHECK_EN when defined.
module tb_gray_counter_ud;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    logic       a_rst, a_en, a_dir, a_load;
    logic [3:0] a_lb, a_gray, a_bin;
    logic       a_tc, a_sat;
    logic       s_rst, s_en, s_dir, s_load;
    logic [3:0] s_lb, s_gray, s_bin;
    logic       s_tc, s_sat;
    logic       w_rst, w_en, w_dir, w_load;
    logic [7:0] w_lb, w_gray, w_bin;
    logic       w_tc, w_sat;
`ifdef GRAY_ONEHOT_CHECK_EN
    logic a_chk, s_chk, w_chk;
`endif

    gray_counter_ud #(.DATA_WIDTH(4), .WRAP_MODE(1), .RESET_BIN(4'd0)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .dir(a_dir), .load(a_load), .load_bin(a_lb),
        .out_gray(a_gray), .out_bin(a_bin), .tc(a_tc), .sat(a_sat)
`ifdef GRAY_ONEHOT_CHECK_EN
        , .chk_err(a_chk)
`endif
    );

    gray_counter_ud #(.DATA_WIDTH(4), .WRAP_MODE(0), .RESET_BIN(4'd3)) dut_s (
        .clk(clk), .rst(s_rst), .en(s_en), .dir(s_dir), .load(s_load), .load_bin(s_lb),
        .out_gray(s_gray), .out_bin(s_bin), .tc(s_tc), .sat(s_sat)
`ifdef GRAY_ONEHOT_CHECK_EN
        , .chk_err(s_chk)
`endif
    );

    gray_counter_ud #(.DATA_WIDTH(8), .WRAP_MODE(1), .RESET_BIN(8'd0)) dut_w (
        .clk(clk), .rst(w_rst), .en(w_en), .dir(w_dir), .load(w_load), .load_bin(w_lb),
        .out_gray(w_gray), .out_bin(w_bin), .tc(w_tc), .sat(w_sat)
`ifdef GRAY_ONEHOT_CHECK_EN
        , .chk_err(w_chk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit reflected gray code listed by value.
    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    // Saturate scenario: load, load_bin, en, dir -> expected bin, tc, sat.
    int sat_tab [12][7] = '{
        '{1, 14, 0, 0, 14, 0, 0},
        '{0,  0, 1, 1, 15, 1, 1},
        '{0,  0, 1, 1, 15, 0, 1},
        '{0,  0, 1, 1, 15, 0, 1},
        '{0,  0, 1, 0, 14, 0, 0},
        '{1,  1, 0, 0,  1, 0, 0},
        '{0,  0, 1, 0,  0, 1, 1},
        '{0,  0, 1, 0,  0, 0, 1},
        '{0,  0, 0, 0,  0, 0, 1},
        '{0,  0, 1, 1,  1, 0, 0},
        '{1, 15, 0, 0, 15, 0, 1},
        '{1,  0, 1, 1,  0, 0, 1}
    };

    typedef struct {
        int v;
        bit tc;
        bit sat;
    } mstate_t;

    mstate_t ma = '{0, 1'b0, 1'b0};
    mstate_t ms = '{0, 1'b0, 1'b0};
    mstate_t mw = '{0, 1'b0, 1'b0};

    // Reference behaviour as integer arithmetic on the counter value.
    function automatic mstate_t model_step(mstate_t s, int width, bit wrap, int rstv,
                                           bit r, bit ld, int lb, bit e, bit d);
        mstate_t n;
        int maxv;
        maxv = (1 << width) - 1;
        n = s;
        n.tc = 1'b0;
        if (r) begin
            n.v = rstv;
            n.sat = 1'b0;
        end else if (ld) begin
            n.v = lb;
            n.sat = !wrap && (lb == 0 || lb == maxv);
        end else if (e) begin
            if (d && s.v == maxv && !wrap) begin
                n.sat = 1'b1;
            end else if (!d && s.v == 0 && !wrap) begin
                n.sat = 1'b1;
            end else begin
                n.v = d ? (s.v + 1) % (maxv + 1) : (s.v + maxv) % (maxv + 1);
                n.tc = d ? (n.v == maxv) : (n.v == 0);
                n.sat = !wrap && n.tc;
            end
        end
        return n;
    endfunction

    task automatic cycle();
        @(posedge clk);
        ma = model_step(ma, 4, 1'b1, 0, a_rst, a_load, int'(a_lb), a_en, a_dir);
        ms = model_step(ms, 4, 1'b0, 3, s_rst, s_load, int'(s_lb), s_en, s_dir);
        mw = model_step(mw, 8, 1'b1, 0, w_rst, w_load, int'(w_lb), w_en, w_dir);
        #1;
    endtask

    task automatic idle_all();
        {a_rst, a_en, a_dir, a_load, a_lb} = '0;
        {s_rst, s_en, s_dir, s_load, s_lb} = '0;
        {w_rst, w_en, w_dir, w_load, w_lb} = '0;
    endtask

    task automatic test_reset();
        idle_all();
        a_rst = 1; a_load = 1; a_lb = 4'd9; a_en = 1;
        s_rst = 1; s_load = 1; s_lb = 4'd9; s_en = 1;
        w_rst = 1; w_load = 1; w_lb = 8'd77; w_en = 1;
        cycle();
        cycle();
        total++;
        if ({a_bin, a_gray, a_tc, a_sat} !== {4'd0, 4'b0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_a: got bin=%0d gray=%b tc=%b sat=%b want 0/0000/0/0",
                     a_bin, a_gray, a_tc, a_sat);
        end
        total++;
        if ({s_bin, s_gray, s_tc, s_sat} !== {4'd3, 4'b0010, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_s: got bin=%0d gray=%b tc=%b sat=%b want 3/0010/0/0",
                     s_bin, s_gray, s_tc, s_sat);
        end
        total++;
        if ({w_bin, w_gray, w_tc, w_sat} !== {8'd0, 8'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_w: got bin=%0d gray=%b want 0", w_bin, w_gray);
        end
`ifdef GRAY_ONEHOT_CHECK_EN
        total++;
        if ({a_chk, s_chk, w_chk} !== 3'b000) begin
            bad++;
            $display("FAIL reset_chk: got %b want 000", {a_chk, s_chk, w_chk});
        end
`endif
        // Load must win over enable once reset drops.
        idle_all();
        s_load = 1; s_lb = 4'd9; s_en = 1; s_dir = 1;
        cycle();
        total++;
        if ({s_bin, s_gray} !== {4'd9, 4'b1101}) begin
            bad++;
            $display("FAIL load_over_en: got bin=%0d gray=%b want 9/1101", s_bin, s_gray);
        end
        idle_all();
    endtask

    task automatic test_up_wrap();
        int pulses = 0;
        idle_all();
        a_rst = 1;
        cycle();
        a_rst = 0; a_en = 1; a_dir = 1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            total++;
            if (a_bin !== 4'(k % 16) || a_gray !== gtab[k % 16] || a_tc !== (k == 15)) begin
                bad++;
                $display("FAIL up_wrap step %0d: got bin=%0d gray=%b tc=%b want %0d/%b/%b",
                         k, a_bin, a_gray, a_tc, k % 16, gtab[k % 16], (k == 15));
            end
            if (a_tc) pulses++;
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL up_wrap_tc_count: got %0d want 1", pulses);
        end
        idle_all();
    endtask

    task automatic test_down_wrap();
        int exp_v;
        idle_all();
        a_load = 1; a_lb = 4'd0;
        cycle();
        a_load = 0; a_en = 1; a_dir = 0;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            exp_v = (16 - k) % 16;
            total++;
            if (a_bin !== 4'(exp_v) || a_gray !== gtab[exp_v] || a_tc !== (exp_v == 0)) begin
                bad++;
                $display("FAIL down_wrap step %0d: got bin=%0d gray=%b tc=%b want %0d/%b/%b",
                         k, a_bin, a_gray, a_tc, exp_v, gtab[exp_v], (exp_v == 0));
            end
        end
        idle_all();
    endtask

    task automatic test_saturate();
        int eb;
        idle_all();
        for (int i = 0; i < 12; i++) begin
            s_load = sat_tab[i][0][0];
            s_lb   = 4'(sat_tab[i][1]);
            s_en   = sat_tab[i][2][0];
            s_dir  = sat_tab[i][3][0];
            cycle();
            eb = sat_tab[i][4];
            total++;
            if (s_bin !== 4'(eb) || s_gray !== gtab[eb] || s_tc !== sat_tab[i][5][0] ||
                s_sat !== sat_tab[i][6][0]) begin
                bad++;
                $display("FAIL saturate row %0d: got bin=%0d gray=%b tc=%b sat=%b want %0d/%b/%0d/%0d",
                         i, s_bin, s_gray, s_tc, s_sat, eb, gtab[eb], sat_tab[i][5],
                         sat_tab[i][6]);
            end
        end
        idle_all();
    endtask

    task automatic test_dir_flip();
        logic [3:0] prev;
        int exp_v;
        idle_all();
        a_load = 1; a_lb = 4'd5;
        cycle();
        prev = a_gray;
        a_load = 0; a_en = 1;
        for (int k = 0; k < 4; k++) begin
            a_dir = (k % 2 == 0);
            cycle();
            exp_v = (k % 2 == 0) ? 6 : 5;
            total++;
            if (a_bin !== 4'(exp_v) || a_gray !== gtab[exp_v] ||
                $countones(a_gray ^ prev) != 1) begin
                bad++;
                $display("FAIL dir_flip step %0d: got bin=%0d gray=%b prev=%b want %0d/%b",
                         k, a_bin, a_gray, prev, exp_v, gtab[exp_v]);
            end
            prev = a_gray;
        end
`ifdef GRAY_ONEHOT_CHECK_EN
        total++;
        if (a_chk !== 1'b0) begin
            bad++;
            $display("FAIL dir_flip_chk: got %b want 0", a_chk);
        end
`endif
        idle_all();
    endtask

    task automatic test_width_sweep();
        bit seen [256];
        int wraps = 0;
        int uniq  = 0;
        int exp_v;
        int dec;
        logic [7:0] prev_bin;
        foreach (seen[i]) seen[i] = 1'b0;
        idle_all();
        w_rst = 1;
        cycle();
        w_rst = 0; w_en = 1; w_dir = 1;
        prev_bin = w_bin;
        for (int k = 1; k <= 300; k++) begin
            cycle();
            exp_v = k % 256;
            dec = -1;
            for (int v = 0; v < 256; v++) begin
                if (8'(v ^ (v >> 1)) == w_gray) dec = v;
            end
            total++;
            if (w_bin !== 8'(exp_v) || w_gray !== 8'(exp_v ^ (exp_v >> 1)) ||
                w_tc !== (exp_v == 255) || dec != int'(w_bin)) begin
                bad++;
                $display("FAIL sweep step %0d: got bin=%0d gray=%b tc=%b decoded=%0d want %0d",
                         k, w_bin, w_gray, w_tc, dec, exp_v);
            end
            if (k <= 256) begin
                if (!seen[w_gray]) uniq++;
                seen[w_gray] = 1'b1;
            end
            if (prev_bin == 8'd255 && w_bin == 8'd0) wraps++;
            prev_bin = w_bin;
        end
        total++;
        if (wraps != 1 || uniq != 256) begin
            bad++;
            $display("FAIL sweep_summary: got wraps=%0d unique=%0d want 1/256", wraps, uniq);
        end
        idle_all();
    endtask

    function automatic logic [7:0] pick_lb(int width);
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'((1 << width) - 1);
        return 8'($urandom_range(0, (1 << width) - 1));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            a_rst = ($urandom_range(0, 49) == 0); a_load = ($urandom_range(0, 9) == 0);
            a_en  = ($urandom_range(0, 9) < 7);   a_dir  = 1'($urandom_range(0, 1));
            a_lb  = 4'(pick_lb(4));
            s_rst = ($urandom_range(0, 49) == 0); s_load = ($urandom_range(0, 9) == 0);
            s_en  = ($urandom_range(0, 9) < 7);   s_dir  = 1'($urandom_range(0, 1));
            s_lb  = 4'(pick_lb(4));
            w_rst = ($urandom_range(0, 49) == 0); w_load = ($urandom_range(0, 9) == 0);
            w_en  = ($urandom_range(0, 9) < 7);   w_dir  = 1'($urandom_range(0, 1));
            w_lb  = pick_lb(8);
            cycle();
            total++;
            if ({a_bin, a_gray, a_tc, a_sat} !==
                {4'(ma.v), 4'(ma.v ^ (ma.v >> 1)), ma.tc, ma.sat}) begin
                bad++;
                $display("FAIL random_a cyc %0d: got bin=%0d tc=%b sat=%b want %0d/%b/%b",
                         n, a_bin, a_tc, a_sat, ma.v, ma.tc, ma.sat);
            end
            total++;
            if ({s_bin, s_gray, s_tc, s_sat} !==
                {4'(ms.v), 4'(ms.v ^ (ms.v >> 1)), ms.tc, ms.sat}) begin
                bad++;
                $display("FAIL random_s cyc %0d: got bin=%0d tc=%b sat=%b want %0d/%b/%b",
                         n, s_bin, s_tc, s_sat, ms.v, ms.tc, ms.sat);
            end
            total++;
            if ({w_bin, w_gray, w_tc, w_sat} !==
                {8'(mw.v), 8'(mw.v ^ (mw.v >> 1)), mw.tc, mw.sat}) begin
                bad++;
                $display("FAIL random_w cyc %0d: got bin=%0d tc=%b sat=%b want %0d/%b/%b",
                         n, w_bin, w_tc, w_sat, mw.v, mw.tc, mw.sat);
            end
        end
`ifdef GRAY_ONEHOT_CHECK_EN
        total++;
        if ({a_chk, s_chk, w_chk} !== 3'b000) begin
            bad++;
            $display("FAIL random_chk: got %b want 000", {a_chk, s_chk, w_chk});
        end
`endif
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_dir_flip();
        test_width_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
